// File: rtl/perm_pkg.sv
// perm_pkg: shared types, widths and steering helpers for the MinBD
// four-port permutation network. Flit field widths live here so that
// every block agrees on the flit_t layout.
package perm_pkg;

   localparam int FLIT_W    = 64;   // payload width, carried untouched
   localparam int AGE_W     = 8;    // larger age = older flit
   localparam int ID_W      = 4;    // source node id width
   localparam int NUM_PORTS = 4;

   // Router ports, also used as indices into per-port arrays.
   typedef enum logic [1:0] {
      PORT_N = 2'd0,
      PORT_E = 2'd1,
      PORT_S = 2'd2,
      PORT_W = 2'd3
   } port_e;

   // Steering rule applied by an arbitration block after picking a winner.
   typedef enum logic [1:0] {
      STEER = 2'd0,   // stage 1: out0 -> block X (ports 0/2), out1 -> block Y (ports 1/3)
      P02   = 2'd1,   // stage 2: out0 -> port 0, out1 -> port 2
      P13   = 2'd2    // stage 2: out0 -> port 1, out1 -> port 3
   } arb_mode_e;

   typedef struct packed {
      logic              vld;
      logic [3:0]        ppv;
      logic [AGE_W-1:0]  age;
      logic [ID_W-1:0]   src;
      logic [FLIT_W-1:0] payload;
   } flit_t;

   // True when the flit can only make progress through ports 1/3,
   // i.e. it should be sent towards the lower (Y) stage-2 block.
   function automatic logic ppv_prefers_lo(input logic [3:0] ppv);
      return (ppv[1] | ppv[3]) & ~ppv[0] & ~ppv[2];
   endfunction

   // True when the winner of a block should take that block's out1.
   function automatic logic winner_takes_out1(input arb_mode_e mode,
                                              input logic [3:0] ppv);
      logic r;
      r = 1'b0;
      case (mode)
         STEER:   r = ppv_prefers_lo(ppv);
         P02:     r = ppv[2] & ~ppv[0];
         P13:     r = ppv[3] & ~ppv[1];
         default: r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/perm_arb_block.sv
// perm_arb_block: 2x2 arbitration cell. Ranks its two inputs
// (golden > older > round-robin), then places the winner on out0 or out1
// according to MODE; the loser always takes the other output, so both
// input flits always leave the cell.
module perm_arb_block
   import perm_pkg::*;
#(
   parameter arb_mode_e MODE = STEER
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [ID_W-1:0] golden_id_i,
   input  flit_t           up_i,
   input  flit_t           lo_i,
   output flit_t           out0_o,
   output flit_t           out1_o
);

   logic  rr_q, rr_d;
   logic  up_gold, lo_gold;
   logic  up_wins;
   logic  rr_used;
   logic  win_to_out1;
   flit_t winner, loser;

   // Winner selection and steering; rr only advances when it broke a tie.
   always_comb begin
      up_wins     = 1'b1;
      rr_used     = 1'b0;
      up_gold     = (up_i.src == golden_id_i);
      lo_gold     = (lo_i.src == golden_id_i);
      if (up_i.vld && lo_i.vld) begin
         if (up_gold != lo_gold) begin
            up_wins = up_gold;
         end else if (up_i.age != lo_i.age) begin
            up_wins = (up_i.age > lo_i.age);
         end else begin
            rr_used = 1'b1;
            up_wins = ~rr_q;
         end
      end else begin
         // A lone valid flit wins; with nothing valid the choice is moot.
         up_wins = up_i.vld | ~lo_i.vld;
      end
      winner      = up_wins ? up_i : lo_i;
      loser       = up_wins ? lo_i : up_i;
      win_to_out1 = winner_takes_out1(MODE, winner.ppv);
      out0_o      = win_to_out1 ? loser  : winner;
      out1_o      = win_to_out1 ? winner : loser;
      rr_d        = rr_q ^ rr_used;
   end

   // Round-robin tie-break bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_q <= 1'b0;
      end else begin
         rr_q <= rr_d;
      end
   end

endmodule

// File: rtl/permutation_network_pipe.sv
// permutation_network_pipe: two-stage, four-port pipelined permutation
// network for the MinBD deflection router. Stage 1 (blocks A, B) pairs
// N/E and S/W and steers towards the correct stage-2 half; stage 2
// (blocks X, Y) assigns final ports. Every valid input flit leaves on
// exactly one output two edges after it is sampled; nothing is dropped.
// Optional feature macro: PERM_STATS_EN adds per-port deflection counters
// (stat_clr / stat_defl_cnt). Flit field widths are set in perm_pkg.
module permutation_network_pipe
   import perm_pkg::*;
#(
   parameter int NUM_NODES     = 16,
   parameter int GOLDEN_PERIOD = 256
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_PORTS-1:0]        in_vld,
   input  logic [NUM_PORTS*FLIT_W-1:0] in_flit,
   input  logic [NUM_PORTS*4-1:0]      in_ppv,
   input  logic [NUM_PORTS*AGE_W-1:0]  in_age,
   input  logic [NUM_PORTS*ID_W-1:0]   in_src,
   output logic [NUM_PORTS-1:0]        out_vld,
   output logic [NUM_PORTS*FLIT_W-1:0] out_flit,
   output logic [NUM_PORTS*4-1:0]      out_ppv,
   output logic [NUM_PORTS-1:0]        out_defl,
   output logic [ID_W-1:0]             golden_id
`ifdef PERM_STATS_EN
   ,
   input  logic                        stat_clr,
   output logic [NUM_PORTS*16-1:0]     stat_defl_cnt
`endif
);

   localparam int EPOCH_W = (GOLDEN_PERIOD > 1) ? $clog2(GOLDEN_PERIOD) : 1;
   localparam logic [EPOCH_W-1:0] EPOCH_LAST  = EPOCH_W'(GOLDEN_PERIOD - 1);
   localparam logic [ID_W-1:0]    GOLDEN_LAST = ID_W'(NUM_NODES - 1);

   // Stage-1 register slots.
   localparam int S1_A_UP = 0;
   localparam int S1_A_LO = 1;
   localparam int S1_B_UP = 2;
   localparam int S1_B_LO = 3;

   genvar gi;

   // ---------------------------------------------------------------
   // Golden epoch
   // ---------------------------------------------------------------
   logic [EPOCH_W-1:0] epoch_q, epoch_d;
   logic [ID_W-1:0]    golden_q, golden_d;

   // Epoch counter wraps at GOLDEN_PERIOD-1 and advances golden_id on that edge.
   always_comb begin
      epoch_d  = epoch_q + EPOCH_W'(1);
      golden_d = golden_q;
      if (epoch_q == EPOCH_LAST) begin
         epoch_d  = '0;
         golden_d = (golden_q == GOLDEN_LAST) ? '0 : golden_q + ID_W'(1);
      end
   end

   // Golden epoch state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         epoch_q  <= '0;
         golden_q <= '0;
      end else begin
         epoch_q  <= epoch_d;
         golden_q <= golden_d;
      end
   end

   assign golden_id = golden_q;

   // ---------------------------------------------------------------
   // Stage 1: blocks A (N,E) and B (S,W)
   // ---------------------------------------------------------------
   flit_t in_f [NUM_PORTS];
   flit_t s1_d [NUM_PORTS];
   flit_t s1_q [NUM_PORTS];

   for (gi = 0; gi < NUM_PORTS; gi++) begin : g_in
      assign in_f[gi] = {in_vld[gi],
                         in_ppv[gi*4 +: 4],
                         in_age[gi*AGE_W +: AGE_W],
                         in_src[gi*ID_W +: ID_W],
                         in_flit[gi*FLIT_W +: FLIT_W]};
   end

   perm_arb_block #(.MODE(STEER)) u_blk_a (
      .clk         (clk),
      .rst_n       (rst_n),
      .golden_id_i (golden_q),
      .up_i        (in_f[PORT_N]),
      .lo_i        (in_f[PORT_E]),
      .out0_o      (s1_d[S1_A_UP]),
      .out1_o      (s1_d[S1_A_LO])
   );

   perm_arb_block #(.MODE(STEER)) u_blk_b (
      .clk         (clk),
      .rst_n       (rst_n),
      .golden_id_i (golden_q),
      .up_i        (in_f[PORT_S]),
      .lo_i        (in_f[PORT_W]),
      .out0_o      (s1_d[S1_B_UP]),
      .out1_o      (s1_d[S1_B_LO])
   );

   // Stage-1 pipe register; reset empties the pipe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            s1_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            s1_q[i] <= s1_d[i];
         end
      end
   end

   // ---------------------------------------------------------------
   // Stage 2: block X (ports 0/2) and Y (ports 1/3)
   // ---------------------------------------------------------------
   flit_t s2_d [NUM_PORTS];

   perm_arb_block #(.MODE(P02)) u_blk_x (
      .clk         (clk),
      .rst_n       (rst_n),
      .golden_id_i (golden_q),
      .up_i        (s1_q[S1_A_UP]),
      .lo_i        (s1_q[S1_B_UP]),
      .out0_o      (s2_d[PORT_N]),
      .out1_o      (s2_d[PORT_S])
   );

   perm_arb_block #(.MODE(P13)) u_blk_y (
      .clk         (clk),
      .rst_n       (rst_n),
      .golden_id_i (golden_q),
      .up_i        (s1_q[S1_A_LO]),
      .lo_i        (s1_q[S1_B_LO]),
      .out0_o      (s2_d[PORT_E]),
      .out1_o      (s2_d[PORT_W])
   );

   logic [NUM_PORTS-1:0]        out_vld_d,  out_vld_q;
   logic [NUM_PORTS*4-1:0]      out_ppv_d,  out_ppv_q;
   logic [NUM_PORTS*FLIT_W-1:0] out_flit_d, out_flit_q;
   logic [NUM_PORTS-1:0]        out_defl_d, out_defl_q;
   logic [NUM_PORTS-1:0]        unused_s2_fields;

   // A flit is deflected when it lands on a port its ppv does not mark productive.
   for (gi = 0; gi < NUM_PORTS; gi++) begin : g_out
      assign out_vld_d[gi]                   = s2_d[gi].vld;
      assign out_ppv_d[gi*4 +: 4]            = s2_d[gi].ppv;
      assign out_flit_d[gi*FLIT_W +: FLIT_W] = s2_d[gi].payload;
      assign out_defl_d[gi]                  = s2_d[gi].vld & ~s2_d[gi].ppv[gi];
      // Age and source are consumed by arbitration only; they do not leave the network.
      assign unused_s2_fields[gi]            = ^{s2_d[gi].age, s2_d[gi].src};
   end

   // Stage-2 (output link) register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_vld_q  <= '0;
         out_ppv_q  <= '0;
         out_flit_q <= '0;
         out_defl_q <= '0;
      end else begin
         out_vld_q  <= out_vld_d;
         out_ppv_q  <= out_ppv_d;
         out_flit_q <= out_flit_d;
         out_defl_q <= out_defl_d;
      end
   end

   assign out_vld  = out_vld_q;
   assign out_ppv  = out_ppv_q;
   assign out_flit = out_flit_q;
   assign out_defl = out_defl_q;

`ifdef PERM_STATS_EN
   // ---------------------------------------------------------------
   // Per-port saturating deflection counters
   // ---------------------------------------------------------------
   for (gi = 0; gi < NUM_PORTS; gi++) begin : g_stat
      logic [15:0] cnt_q, cnt_d;

      // Clear beats a same-cycle increment; the count sticks at all-ones.
      always_comb begin
         cnt_d = cnt_q;
         if (stat_clr) begin
            cnt_d = '0;
         end else if (out_defl_d[gi] && (cnt_q != 16'hFFFF)) begin
            cnt_d = cnt_q + 16'd1;
         end
      end

      // Counter state.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign stat_defl_cnt[gi*16 +: 16] = cnt_q;
   end
`endif

endmodule

// File: tb/tb_permutation_network_pipe.sv
// tb_permutation_network_pipe: directed bench for the permutation network,
// built with GOLDEN_PERIOD=4 so golden epochs are short. Optional
// PERM_STATS_EN section exercises the deflection counters.
module tb_permutation_network_pipe;
   import perm_pkg::*;

   logic                   clk   = 1'b0;
   logic                   rst_n = 1'b0;
   logic [3:0]             in_vld;
   logic [4*FLIT_W-1:0]    in_flit;
   logic [15:0]            in_ppv;
   logic [4*AGE_W-1:0]     in_age;
   logic [4*ID_W-1:0]      in_src;
   logic [3:0]             out_vld;
   logic [4*FLIT_W-1:0]    out_flit;
   logic [15:0]            out_ppv;
   logic [3:0]             out_defl;
   logic [ID_W-1:0]        golden_id;
`ifdef PERM_STATS_EN
   logic                   stat_clr = 1'b0;
   logic [63:0]            stat_defl_cnt;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   permutation_network_pipe #(
      .NUM_NODES     (16),
      .GOLDEN_PERIOD (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_vld    (in_vld),
      .in_flit   (in_flit),
      .in_ppv    (in_ppv),
      .in_age    (in_age),
      .in_src    (in_src),
      .out_vld   (out_vld),
      .out_flit  (out_flit),
      .out_ppv   (out_ppv),
      .out_defl  (out_defl),
      .golden_id (golden_id)
`ifdef PERM_STATS_EN
      ,
      .stat_clr      (stat_clr),
      .stat_defl_cnt (stat_defl_cnt)
`endif
   );

   task automatic chk4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      in_vld  = '0;
      in_flit = '0;
      in_ppv  = '0;
      in_age  = '0;
      in_src  = '0;
   endtask

   task automatic put(input int p, input logic [63:0] pay, input logic [3:0] ppv,
                      input logic [AGE_W-1:0] age, input logic [ID_W-1:0] src);
      in_vld[p]                   = 1'b1;
      in_flit[p*FLIT_W +: FLIT_W] = pay;
      in_ppv[p*4 +: 4]            = ppv;
      in_age[p*AGE_W +: AGE_W]    = age;
      in_src[p*ID_W +: ID_W]      = src;
   endtask

   function automatic logic [63:0] flit_at(input int q);
      return out_flit[q*FLIT_W +: FLIT_W];
   endfunction

   function automatic logic [3:0] ppv_at(input int q);
      return out_ppv[q*4 +: 4];
   endfunction

   task automatic do_reset();
      rst_n = 1'b0;
      clr_in();
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   logic [3:0]  prev_vld;
   logic [63:0] prev_pay [4];
   logic [3:0]  prev_ppv [4];
   int          hits;

   initial begin
      clr_in();

      // ---- reset state ----
      do_reset();
      $display("[TB] txn reset");
      chk4 ("rst_out_vld",  out_vld,  4'b0000);
      chk4 ("rst_out_defl", out_defl, 4'b0000);
      chk4 ("rst_golden",   golden_id, 4'd0);
      chk64("rst_flit0",    flit_at(0), 64'd0);
      chk4 ("rst_ppv0",     ppv_at(0), 4'b0000);

      // ---- single N flit towards S ----
      put(0, 64'hDEAD_BEEF_0000_0001, 4'b0100, 8'd3, 4'd7);
      tick();
      clr_in();
      chk4("t1_not_yet", out_vld, 4'b0000);
      tick();
      $display("[TB] txn single N->S");
      chk4 ("t1_vld",  out_vld,  4'b0100);
      chk4 ("t1_defl", out_defl, 4'b0000);
      chk64("t1_flit", flit_at(2), 64'hDEAD_BEEF_0000_0001);
      chk4 ("t1_ppv",  ppv_at(2), 4'b0100);
      tick();
      chk4("t1_gone", out_vld, 4'b0000);

      // ---- back-to-back: age contest, then all four ports ----
      // Same src everywhere so the golden id cannot influence either case.
      put(0, 64'h0000_0000_0000_00A5, 4'b0001, 8'd5, 4'd7);
      put(1, 64'h0000_0000_0000_00E9, 4'b0001, 8'd9, 4'd7);
      tick();
      clr_in();
      put(0, 64'h0000_0000_0000_00A0, 4'b0001, 8'd10, 4'd7);
      put(1, 64'h0000_0000_0000_00A1, 4'b0100, 8'd20, 4'd7);
      put(2, 64'h0000_0000_0000_00A2, 4'b0010, 8'd30, 4'd7);
      put(3, 64'h0000_0000_0000_00A3, 4'b1000, 8'd40, 4'd7);
      tick();
      clr_in();
      $display("[TB] txn age contest N5/E9");
      chk4 ("t2_vld",   out_vld,  4'b0011);
      chk4 ("t2_defl",  out_defl, 4'b0010);
      chk64("t2_port0", flit_at(0), 64'h00E9);
      chk64("t2_port1", flit_at(1), 64'h00A5);
      chk4 ("t2_ppv0",  ppv_at(0), 4'b0001);
      tick();
      $display("[TB] txn four-port");
      chk4 ("t4p_vld",   out_vld,  4'b1111);
      chk4 ("t4p_defl",  out_defl, 4'b0011);
      chk64("t4p_port0", flit_at(0), 64'h00A2);
      chk64("t4p_port1", flit_at(1), 64'h00A0);
      chk64("t4p_port2", flit_at(2), 64'h00A1);
      chk64("t4p_port3", flit_at(3), 64'h00A3);

      // ---- full ties: round-robin alternates N,E,N,E ----
      do_reset();
      for (int i = 0; i <= 4; i++) begin
         clr_in();
         if (i < 4) begin
            put(0, 64'hC0 + 64'(i), 4'b0010, 8'd4, 4'd2);
            put(1, 64'hD0 + 64'(i), 4'b0010, 8'd4, 4'd2);
         end
         tick();
         if (i > 0) begin
            $display("[TB] txn rr tie %0d", i - 1);
            chk4 ($sformatf("rr%0d_vld",  i - 1), out_vld,  4'b0011);
            chk4 ($sformatf("rr%0d_defl", i - 1), out_defl, 4'b0001);
            chk64($sformatf("rr%0d_win",  i - 1), flit_at(1),
                  ((i - 1) % 2 == 0) ? 64'hC0 + 64'(i - 1) : 64'hD0 + 64'(i - 1));
            chk64($sformatf("rr%0d_lose", i - 1), flit_at(0),
                  ((i - 1) % 2 == 0) ? 64'hD0 + 64'(i - 1) : 64'hC0 + 64'(i - 1));
         end
      end

      // ---- golden epochs (period 4, 16 nodes) and golden priority ----
      do_reset();
      for (int e = 1; e <= 68; e++) begin
         tick();
         chk4($sformatf("golden_e%0d", e), golden_id, 4'((e / 4) % 16));
         if (e == 4) begin
            put(0, 64'h0000_0000_0000_0601, 4'b0001, 8'd0,   4'd1);
            put(1, 64'h0000_0000_0000_0602, 4'b0001, 8'd255, 4'd2);
         end
         if (e == 5) clr_in();
         if (e == 6) begin
            $display("[TB] txn golden beats age");
            chk4 ("gold_vld",   out_vld,  4'b0011);
            chk4 ("gold_defl",  out_defl, 4'b0010);
            chk64("gold_port0", flit_at(0), 64'h0601);
            chk64("gold_port1", flit_at(1), 64'h0602);
         end
      end

      // ---- conservation under random traffic ----
      prev_vld = '0;
      for (int i = 0; i <= 400; i++) begin
         clr_in();
         if (i < 400) begin
            for (int p = 0; p < 4; p++) begin
               if (i < 200 || $urandom_range(0, 3) != 0) begin
                  put(p, {16'hC0DE, 16'(i), 28'h0, 4'(p)}, 4'($urandom),
                      AGE_W'($urandom_range(0, 3)), ID_W'($urandom));
               end
            end
         end
         tick();
         if (i > 0) begin
            chk64($sformatf("cons%0d_pop", i - 1), 64'($countones(out_vld)),
                  64'($countones(prev_vld)));
            for (int p = 0; p < 4; p++) begin
               if (prev_vld[p]) begin
                  hits = 0;
                  for (int q = 0; q < 4; q++) begin
                     if (out_vld[q] && flit_at(q) == prev_pay[p] && ppv_at(q) == prev_ppv[p])
                        hits++;
                  end
                  chk64($sformatf("cons%0d_in%0d_once", i - 1, p), 64'(hits), 64'd1);
               end
            end
         end
         prev_vld = in_vld;
         for (int p = 0; p < 4; p++) begin
            prev_pay[p] = in_flit[p*FLIT_W +: FLIT_W];
            prev_ppv[p] = in_ppv[p*4 +: 4];
         end
      end
      $display("[TB] txn random conservation done");

      // ---- reset mid-stream ----
      do_reset();
      put(0, 64'h0000_0000_0000_00A0, 4'b0001, 8'd10, 4'd7);
      put(1, 64'h0000_0000_0000_00A1, 4'b0100, 8'd20, 4'd7);
      put(2, 64'h0000_0000_0000_00A2, 4'b0010, 8'd30, 4'd7);
      put(3, 64'h0000_0000_0000_00A3, 4'b1000, 8'd40, 4'd7);
      tick();
      clr_in();
      put(0, 64'h0000_0000_0000_0BAD, 4'b0100, 8'd1, 4'd7);
      tick();
      chk4("mid_before_rst", out_vld, 4'b1111);
      #2;
      rst_n = 1'b0;
      #1;
      $display("[TB] txn async reset mid-stream");
      chk4("mid_rst_vld",    out_vld,  4'b0000);
      chk4("mid_rst_defl",   out_defl, 4'b0000);
      chk4("mid_rst_golden", golden_id, 4'd0);
      clr_in();
      tick();
      tick();
      rst_n = 1'b1;
      put(0, 64'hDEAD_BEEF_0000_0001, 4'b0100, 8'd3, 4'd7);
      tick();
      clr_in();
      chk4("mid_flushed", out_vld, 4'b0000);
      tick();
      $display("[TB] txn single N->S after reset");
      chk4 ("mid_t1_vld",  out_vld,  4'b0100);
      chk4 ("mid_t1_defl", out_defl, 4'b0000);
      chk64("mid_t1_flit", flit_at(2), 64'hDEAD_BEEF_0000_0001);

`ifdef PERM_STATS_EN
      // ---- deflection counter saturation and clear ----
      do_reset();
      put(0, 64'h5A5A, 4'b0000, 8'd0, 4'd0);
      repeat (70000) tick();
      $display("[TB] txn stats saturate");
      chk64("stat_sat_p0", 64'(stat_defl_cnt[15:0]), 64'hFFFF);
      chk64("stat_p1",     64'(stat_defl_cnt[31:16]), 64'h0);
      stat_clr = 1'b1;
      tick();
      stat_clr = 1'b0;
      chk64("stat_clr_p0", 64'(stat_defl_cnt[15:0]), 64'h0);
      tick();
      chk64("stat_resume_p0", 64'(stat_defl_cnt[15:0]), 64'h1);
      clr_in();
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
